logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit bitwise logic unit (AND, OR, NOT, NAND, NOR, XOR, XNOR) between NUM_REQ requesters. Each requester presents an opcode and two operands over a valid/ready handshake. The block grants one requester, registers its operands, evaluates the selected gate function, and returns the result tagged with the requester index over a valid/ready response port. It sits between the client blocks and the gate-level datapath so that only one logic unit is instantiated.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- WIDTH, 8: operand and result width in bits; minimum 1.
- ID_W, $clog2(NUM_REQ): width of the requester index.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NUM_REQ  bit i set: requester i has an operation pending.
- req_ready  output  NUM_REQ  one-hot grant; bit i set: requester i's operation is accepted this cycle.
- req_op  input  3*NUM_REQ  opcode for requester i in bits [3i+2:3i].
- req_a  input  WIDTH*NUM_REQ  operand A for requester i in bits [WIDTH*i +: WIDTH].
- req_b  input  WIDTH*NUM_REQ  operand B for requester i in the same slicing.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  WIDTH  result.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_err  output  1  set when the opcode was illegal.

## Operation
- Opcodes: 0 AND, 1 OR, 2 NOT (~A; B ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal. An illegal opcode produces rsp_data = 0 and rsp_err = 1.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any req_valid bit is set, grant the winner. Drive req_ready[winner] = 1 combinationally in this cycle. Capture op, A, B and ID into registers. Go to EXEC. Otherwise stay in IDLE.
  - EXEC: compute the gate function on the captured operands. Register the result into rsp_data and rsp_err, and the ID into rsp_id. Go to RESP.
  - RESP: hold rsp_valid = 1 with rsp_data, rsp_id and rsp_err stable. When rsp_ready = 1, go to IDLE.
- req_ready is 0 in EXEC and RESP. At most one req_ready bit is set in any cycle. A transfer occurs only when req_valid[i] and req_ready[i] are both 1.
- Round-robin arbitration uses a pointer ptr (ID_W bits).
  - Search order: ptr, ptr+1, …, wrapping modulo NUM_REQ. The first requester with req_valid set wins.
  - On each grant, ptr becomes (winner+1) mod NUM_REQ. Wrap from NUM_REQ-1 goes to 0.
  - ptr changes only on a grant.
- Requesters must hold req_op, req_a and req_b stable while req_valid is high. The block samples them only in the grant cycle. Later changes do not affect the operation in flight.
- A requester may drop req_valid before it is granted; it is simply not selected.
- Reset values (asynchronous, while rst_n = 0):
  - state = IDLE, ptr = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0.
  - Captured registers = 0.
  - req_ready = 0 while rst_n = 0.
- Reset mid-operation: the in-flight operation is discarded with no response. After rst_n deasserts, the first grant starts the search from requester 0.

## Timing
- Grant cycle T (IDLE, req_ready high) → EXEC at T+1 → rsp_valid rises at T+2.
- Request-to-response latency is 2 cycles.
- With rsp_ready held at 1, the response is accepted at T+2, the block is in IDLE at T+3, and the next grant can occur at T+3. Maximum throughput is one operation per 3 cycles.
- If rsp_ready is low, the block stalls in RESP indefinitely with outputs stable. No new grants are made during the stall.
- rsp_valid deasserts in the cycle after the accepting edge.
- req_ready is combinational from state, ptr and req_valid. It has no combinational dependence on rsp_ready.

## Test plan
- Reset, then single request: after rst_n deasserts, requester 2 presents op=0 (AND), A=0xF0, B=0x3C. Required: req_ready=0b0100 in the grant cycle; two cycles later rsp_valid=1, rsp_data=0x30, rsp_id=2, rsp_err=0.
- Opcode sweep: one requester runs all opcodes 0–7 with A=0xA5, B=0x0F. Required rsp_data in order: 0x05, 0xAF, 0x5A, 0xFA, 0x50, 0xAA, 0x55, 0x00. rsp_err=1 only for op 7.
- Round-robin fairness: all four req_valid bits held high, rsp_ready=1. Required grant order 0, 1, 2, 3, 0, 1. Each grant is exactly 3 cycles after the previous one, and req_ready is one-hot every cycle.
- Pointer wrap and skip: ptr=3 after a grant to requester 2; only requesters 1 and 3 are valid. Required: requester 3 is granted first, then requester 1.
- Backpressure: rsp_ready held at 0 for 5 cycles while another requester is valid. Required: rsp_valid, rsp_data and rsp_id stay stable; req_ready stays 0; the grant resumes in the cycle after rsp_ready=1 is accepted.
- Reset mid-operation: assert rst_n=0 during EXEC. Required: rsp_valid, rsp_data, rsp_id and req_ready go to 0 immediately. After release with all requesters valid, requester 0 is granted first.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that time-shares one bitwise logic unit between NUM_REQ
// requesters. Each accepted request returns one tagged response.
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  ptr_next;
  logic             found;
  logic             grant;
  int               idx;

  logic [2:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [ID_W-1:0]  id_p0;

  function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    gate_eval = a & b;
      3'd1:    gate_eval = a | b;
      3'd2:    gate_eval = ~a;
      3'd3:    gate_eval = ~(a & b);
      3'd4:    gate_eval = ~(a | b);
      3'd5:    gate_eval = a ^ b;
      3'd6:    gate_eval = ~(a ^ b);
      default: gate_eval = '0;
    endcase
  endfunction

  function automatic logic op_illegal(input logic [2:0] op);
    op_illegal = (op == 3'd7);
  endfunction

  // Search starts at ptr and wraps modulo NUM_REQ; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign grant    = rst_n && (state == S_IDLE) && found;
  assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      op_p0     <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      id_p0     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        // Grant stage: sample the winner's operands once.
        S_IDLE: begin
          if (grant) begin
            op_p0 <= req_op[3*winner +: 3];
            a_p0  <= req_a[WIDTH*winner +: WIDTH];
            b_p0  <= req_b[WIDTH*winner +: WIDTH];
            id_p0 <= winner;
            ptr   <= ptr_next;
            state <= S_EXEC;
          end
        end
        // Execute stage: evaluate the gate function into the response registers.
        S_EXEC: begin
          rsp_data  <= gate_eval(op_p0, a_p0, b_p0);
          rsp_err   <= op_illegal(op_p0);
          rsp_id    <= id_p0;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        // Response stage: hold until the consumer takes it.
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomized and directed bench for logic_unit_arbiter with a queue-based
// scoreboard fed by a transaction-level arbitration model.
module tb_logic_unit_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [IW-1:0]  rsp_id;
  logic           rsp_err;

  logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [W-1:0] data;
    logic       err;
    int         due;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           mptr = 0;
  bit           busy = 1'b0;
  logic [N-1:0] granted_mask = '0;
  int           w;
  logic [N-1:0] exp_ready;
  logic         exp_vld;
  exp_t         e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_result(input int op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return ~a;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return a ^ b;
      6: return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  function automatic int predict(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Monitor / scoreboard: evaluated mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rsp_data", 32'(rsp_data), 32'(0));
      chk("rst_rsp_id", 32'(rsp_id), 32'(0));
      chk("rst_rsp_err", 32'(rsp_err), 32'(0));
      q.delete();
      mptr = 0;
      busy = 1'b0;
      granted_mask = '0;
    end else begin
      w = busy ? -1 : predict(req_valid, mptr);
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      chk("onehot", 32'($onehot0(req_ready)), 32'(1));
      chk("grant", 32'(req_ready), 32'(exp_ready));
      granted_mask = req_ready & req_valid;
      if (w >= 0) begin
        e.id   = w;
        e.data = model_result(int'(req_op[3*w +: 3]), req_a[W*w +: W], req_b[W*w +: W]);
        e.err  = (req_op[3*w +: 3] == 3'd7);
        e.due  = cyc + 2;
        q.push_back(e);
        mptr = (w + 1) % N;
        busy = 1'b1;
      end
      exp_vld = (q.size() > 0) && (cyc >= q[0].due);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
      if (exp_vld) begin
        chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        if (rsp_ready) begin
          void'(q.pop_front());
          busy = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_valid[i]     = 1'b1;
    req_op[3*i +: 3] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  task automatic set_rand(input int i);
    set_req(i, 3'($urandom), W'($urandom), W'($urandom));
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_grant(input int i);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!granted_mask[i] && n < 60);
    if (!granted_mask[i]) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout for requester %0d: no grant within 60 cycles", i);
    end
  endtask

  task automatic wait_any_grant();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (granted_mask == '0 && n < 60);
    if (granted_mask == '0) begin
      checks++;
      errors++;
      $display("FAIL any_grant_timeout: no grant within 60 cycles");
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 100) begin
      step();
      n++;
    end
    if (q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d responses outstanding after 100 cycles", q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;

    // Single request after reset: requester 2, AND of 0xF0 and 0x3C.
    set_req(2, 3'd0, 8'hF0, 8'h3C);
    wait_grant(2);
    clr_req(2);
    wait_idle();

    // Opcode sweep on requester 1.
    for (int op = 0; op < 8; op++) begin
      set_req(1, 3'(op), 8'hA5, 8'h0F);
      wait_grant(1);
      clr_req(1);
      wait_idle();
    end

    // Pointer wrap and skip: grant 2, then only 1 and 3 valid.
    set_rand(2);
    wait_grant(2);
    clr_req(2);
    wait_idle();
    set_rand(1);
    set_rand(3);
    wait_grant(3);
    clr_req(3);
    wait_grant(1);
    clr_req(1);
    wait_idle();

    // Backpressure: response stalled while another requester waits.
    rsp_ready = 1'b0;
    set_rand(0);
    wait_grant(0);
    clr_req(0);
    set_rand(1);
    repeat (6) step();
    rsp_ready = 1'b1;
    wait_grant(1);
    clr_req(1);
    wait_idle();

    // Reset during EXEC, then fairness from requester 0 with everyone valid.
    for (int i = 0; i < N; i++) set_rand(i);
    wait_any_grant();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
    req_valid = '0;
    wait_idle();

    // Randomized traffic with random backpressure and abandoned requests.
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && granted_mask[i]) begin
          if ($urandom_range(1, 0) == 1) set_rand(i);
          else clr_req(i);
        end else if (!req_valid[i]) begin
          if ($urandom_range(3, 0) == 0) set_rand(i);
        end else if ($urandom_range(15, 0) == 0) begin
          clr_req(i);
        end
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
    end
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();
    chk("drain", 32'(q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
